proc_sequencer: RTL and testbench



---
 rtl/proc_pkg.sv | 24 ++
 rtl/instr_fifo.sv | 52 +++++
 rtl/proc_sequencer.sv | 121 ++++++++++++
 tb/tb_proc_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the proc datapath and its instruction sequencer.
package proc_pkg;

  localparam int unsigned INSTR_W = 14;

  // Instruction word layout: {F[1:0], Rx[1:0], Ry[1:0], Data[7:0]}
  localparam int unsigned F_LSB    = 12;
  localparam int unsigned RX_LSB   = 10;
  localparam int unsigned RY_LSB   = 8;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFault
  } seq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue with a combinational head output.
module instr_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               wr,
  input  logic [INSTR_W-1:0] din,
  input  logic               rd,
  output logic [INSTR_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               do_wr, do_rd;

  // Acceptance is judged on the pre-edge flags, so a write into a full queue is dropped
  // even when the head is popped in the same cycle.
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_wr && !do_rd) cnt_q <= cnt_q + CntW'(1);
      else if (do_rd && !do_wr) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == FullCount);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/proc_sequencer.sv
// Issues queued instructions to proc over the w/Done handshake, with a timeout watchdog.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic               InstrWr,
  input  logic               Run,
  input  logic               ErrClr,
  input  logic               Done,
  output logic               w,
  output logic [1:0]         F,
  output logic [1:0]         Rx,
  output logic [1:0]         Ry,
  output logic [7:0]         Data,
  output logic               ProcReset,
  output logic               Full,
  output logic               Empty,
  output logic               Busy,
  output logic               Error,
  output logic [7:0]         IssueCount
);

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  seq_state_e         state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         count_q, count_d;
  logic               error_q, error_d;
  logic               proc_reset_q;
  logic [INSTR_W-1:0] head;
  logic               pop;

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clock(Clock),
    .Reset(Reset),
    .wr   (InstrWr),
    .din  (InstrIn),
    .rd   (pop),
    .dout (head),
    .full (Full),
    .empty(Empty)
  );

  // The timer reads 0 in ISSUE and j in the j-th WAIT cycle, so FAULT lands TIMEOUT cycles
  // after ISSUE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    instr_d = instr_q;
    count_d = count_q;
    error_d = error_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Run && !Empty) begin
          instr_d = head;
          timer_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = timer_q + 8'd1;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 8'd1;
        if (Done) begin
          pop     = 1'b1;
          count_d = count_q + 8'd1;
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          state_d = StFault;
        end
      end
      StFault: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q == StFault) error_d = 1'b1;
    else if (ErrClr)        error_d = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      instr_q      <= '0;
      count_q      <= '0;
      error_q      <= 1'b0;
      proc_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      error_q      <= error_d;
      proc_reset_q <= (state_d == StFault);
    end
  end

  assign w          = (state_q == StIssue);
  assign Busy       = (state_q == StIssue) || (state_q == StWait);
  assign ProcReset  = proc_reset_q;
  assign Error      = error_q;
  assign IssueCount = count_q;
  assign F          = instr_q[F_LSB +: 2];
  assign Rx         = instr_q[RX_LSB +: 2];
  assign Ry         = instr_q[RY_LSB +: 2];
  assign Data       = instr_q[DATA_LSB +: 8];

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small proc responder driving Done.
module tb_proc_sequencer;
  import proc_pkg::*;

  logic               Clock, Reset, InstrWr, Run, ErrClr, Done;
  logic [INSTR_W-1:0] InstrIn;
  logic               w, ProcReset, Full, Empty, Busy, Error;
  logic [1:0]         F, Rx, Ry;
  logic [7:0]         Data, IssueCount;

  int n_chk = 0;
  int n_fail = 0;

  // Responder state
  logic       done_auto;
  int         pend;
  int         done_cnt;
  logic [7:0] regs [4];

  proc_sequencer #(
    .DEPTH  (8),
    .TIMEOUT(15)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .InstrIn   (InstrIn),
    .InstrWr   (InstrWr),
    .Run       (Run),
    .ErrClr    (ErrClr),
    .Done      (Done),
    .w         (w),
    .F         (F),
    .Rx        (Rx),
    .Ry        (Ry),
    .Data      (Data),
    .ProcReset (ProcReset),
    .Full      (Full),
    .Empty     (Empty),
    .Busy      (Busy),
    .Error     (Error),
    .IssueCount(IssueCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // proc model: Done one cycle after ISSUE for load/move, three cycles after for add/sub.
  initial begin
    Done = 1'b0;
    pend = 0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    forever begin
      @(posedge Clock);
      #1;
      Done = 1'b0;
      if (Reset) begin
        pend = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            Done = 1'b1;
            done_cnt++;
            case (F)
              OP_LOAD: regs[Rx] = Data;
              OP_MOVE: regs[Rx] = regs[Ry];
              OP_ADD:  regs[Rx] = regs[Rx] + regs[Ry];
              default: regs[Rx] = regs[Rx] - regs[Ry];
            endcase
          end
        end
        if (w && done_auto) pend = F[1] ? 3 : 1;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         wcnt, widx, waitcnt, pr_cnt, pr_at;
  logic [7:0] last_data;
  logic       seen_ee, got;

  initial begin
    Reset = 1'b1; InstrWr = 1'b0; InstrIn = '0; Run = 1'b0; ErrClr = 1'b0; done_auto = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_w", w, 0);
    chk("rst_procreset", ProcReset, 0);
    chk("rst_fields", {F, Rx, Ry, Data}, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_error", Error, 0);
    chk("rst_count", IssueCount, 0);
    chk("rst_empty_full", {Empty, Full}, 2'b10);

    // Single load R1 <- 0x5A
    Run = 1'b1;
    InstrIn = {OP_LOAD, 2'd1, 2'd0, 8'h5A};
    InstrWr = 1'b1;
    tick();
    InstrWr = 1'b0;
    chk("t1_w_after_write", w, 0);
    chk("t1_not_empty", Empty, 0);
    tick();
    chk("t1_w_issue", w, 1);
    chk("t1_fields", {F, Rx, Data}, {2'b00, 2'b01, 8'h5A});
    tick();
    chk("t1_w_wait", w, 0);
    chk("t1_held", {Busy, Data}, {1'b1, 8'h5A});
    tick();
    chk("t1_count", IssueCount, 1);
    chk("t1_idle", {Busy, Empty}, 2'b01);

    // load R0<-3, load R1<-4, add R0,R1 back-to-back
    wcnt = 0; widx = -1; waitcnt = 0;
    for (int i = 0; i < 12; i++) begin
      InstrWr = (i < 3);
      case (i)
        0:       InstrIn = {OP_LOAD, 2'd0, 2'd0, 8'h03};
        1:       InstrIn = {OP_LOAD, 2'd1, 2'd0, 8'h04};
        default: InstrIn = {OP_ADD, 2'd0, 2'd1, 8'h00};
      endcase
      tick();
      if (w) begin wcnt++; widx = i; end
      if (Busy && !w && F == OP_ADD) waitcnt++;
    end
    InstrWr = 1'b0;
    chk("t2_w_pulses", wcnt, 3);
    chk("t2_last_issue_idx", widx, 7);
    chk("t2_add_wait_len", waitcnt, 3);
    chk("t2_count", IssueCount, 4);
    chk("t2_r0", regs[0], 8'h07);

    // Fill with Run=0, one extra word dropped
    Run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      InstrWr = 1'b1;
      InstrIn = {OP_LOAD, 2'(i), 2'd0, 8'(8'h10 + i)};
      tick();
      if (i == 6) chk("t3_not_full_7", Full, 0);
      if (i == 7) chk("t3_full_8", Full, 1);
    end
    InstrWr = 1'b0;
    chk("t3_full_idle", {Full, Busy, w}, 3'b100);
    Run = 1'b1;
    wcnt = 0; last_data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (w) begin wcnt++; last_data = Data; end
    end
    chk("t3_issued", wcnt, 8);
    chk("t3_last_data", last_data, 8'h17);
    chk("t3_count", IssueCount, 12);
    chk("t3_empty", Empty, 1);

    // Watchdog: first entry hangs, second completes
    done_auto = 1'b0;
    InstrWr = 1'b1;
    InstrIn = {OP_LOAD, 2'd2, 2'd0, 8'hA1};
    tick();
    InstrIn = {OP_LOAD, 2'd3, 2'd0, 8'hB2};
    tick();
    InstrWr = 1'b0;
    chk("t4_issue_a", {w, Data}, {1'b1, 8'hA1});
    pr_cnt = 0; pr_at = 0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (ProcReset) begin
        pr_cnt++;
        if (pr_at == 0) pr_at = j;
      end
    end
    chk("t4_pr_count", pr_cnt, 1);
    chk("t4_pr_offset", pr_at, 15);
    chk("t4_err_during_fault", Error, 0);
    done_auto = 1'b1;
    tick();
    chk("t4_after_fault", {Error, ProcReset, IssueCount}, {1'b1, 1'b0, 8'd12});
    tick();
    chk("t4_issue_b", {w, Data}, {1'b1, 8'hB2});
    tick();
    tick();
    chk("t4_count", {IssueCount, Empty}, {8'd13, 1'b1});
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    chk("t4_errclr", Error, 0);

    // Reset two cycles into an add WAIT
    InstrWr = 1'b1;
    InstrIn = {OP_ADD, 2'd0, 2'd1, 8'h00};
    tick();
    InstrIn = {OP_LOAD, 2'd1, 2'd0, 8'h33};
    tick();
    InstrWr = 1'b0;
    chk("t5_issue_add", {w, F}, {1'b1, OP_ADD});
    tick();
    tick();
    chk("t5_in_wait", {Busy, w}, 2'b10);
    Reset = 1'b1;
    tick();
    chk("t5_rst_flags", {w, ProcReset, Busy, Error, Empty, Full}, 6'b000010);
    chk("t5_rst_vals", {IssueCount, F, Rx, Ry, Data}, 0);
    Reset = 1'b0;
    tick();
    chk("t5_post_rst", {w, Busy, Empty, ProcReset}, 4'b0010);

    // Write while Full coinciding with a Done pop
    Run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      InstrWr = 1'b1;
      InstrIn = {OP_LOAD, 2'(i), 2'd0, 8'(8'h20 + i)};
      tick();
    end
    InstrWr = 1'b0;
    chk("t6_full", Full, 1);
    Run = 1'b1;
    tick();
    chk("t6_issue", w, 1);
    tick();
    chk("t6_wait_full_done", {Full, Done}, 2'b11);
    InstrWr = 1'b1;
    InstrIn = {OP_LOAD, 2'd0, 2'd0, 8'hEE};
    tick();
    InstrWr = 1'b0;
    chk("t6_after_pop", {Full, Empty, IssueCount}, {1'b0, 1'b0, 8'd1});
    wcnt = 0; seen_ee = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (w) begin
        wcnt++;
        if (Data == 8'hEE) seen_ee = 1'b1;
      end
    end
    chk("t6_remaining", wcnt, 7);
    chk("t6_dropped", seen_ee, 0);
    chk("t6_count", {IssueCount, Empty}, {8'd8, 1'b1});

    // IssueCount wrap after 256 completions
    InstrWr = 1'b1;
    InstrIn = {OP_MOVE, 2'd0, 2'd1, 8'h00};
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (done_cnt == 256) begin
        got = 1'b1;
        break;
      end
    end
    InstrWr = 1'b0;
    chk("t6_reached_256", got, 1);
    chk("t6_count_255", IssueCount, 8'hFF);
    tick();
    chk("t6_count_wrap", IssueCount, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
